inst_axi_rd_bridge: RTL and testbench

- Sits directly upstream of if_stage, between its SRAM-like instruction port and the AXI read channel toward the system interconnect.
- Converts single-word read requests (req/addr_ok/data_ok) into single-beat AXI4 read transactions.
- Supports one AXI transaction in flight plus one pending request slot, so a flush-time redirect request issued while a fetch is outstanding is never lost.
- Returns data strictly in request order.

---
 rtl/inst_axi_rd_bridge_pkg.sv | 16 +
 rtl/inst_req_slot.sv | 25 ++
 rtl/inst_axi_rd_bridge.sv | 114 +++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// rtl/inst_axi_rd_bridge_pkg.sv - shared state encodings and AXI constants for the instruction read bridge
package inst_axi_rd_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    localparam logic [3:0] AXI_ID_INST    = 4'h0;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/inst_req_slot.sv
// rtl/inst_req_slot.sv - one-entry valid+address holding slot with same-cycle pop and push
module inst_req_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic        valid,
    output logic [31:0] addr
);

    // Push wins over pop so a freed entry can be refilled in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= 32'd0;
        end else if (push) begin
            valid <= 1'b1;
            addr  <= push_addr;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// rtl/inst_axi_rd_bridge.sv - SRAM-like fetch port to single-beat AXI read bridge; INST_BRIDGE_RERR_EN adds inst_sram_rerr
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter logic [3:0] ARID_VAL    = AXI_ID_INST,
    parameter logic [1:0] RESET_STATE = 2'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
`ifdef INST_BRIDGE_RERR_EN
    ,
    output logic        inst_sram_rerr
`endif
);

    state_t      state;
    state_t      state_nxt;
    logic        beat_done;
    logic        accept;
    logic        slot_push;
    logic        slot_pop;
    logic        pend_valid;
    logic [31:0] pend_addr;

    assign arid    = ARID_VAL;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = (state == ST_AR);
    assign rready  = (state == ST_R);

    assign beat_done = rvalid && (state == ST_R);
    assign accept    = !reset && inst_sram_req &&
                       ((state == ST_IDLE) || !pend_valid || beat_done);

    // A request accepted while busy parks in the slot, except when the beat
    // completes with nothing pending: then it goes straight to araddr.
    assign slot_push = accept && (state != ST_IDLE) && !(beat_done && !pend_valid);
    assign slot_pop  = beat_done && pend_valid;

    assign inst_sram_addr_ok = accept;
    assign inst_sram_data_ok = !reset && beat_done;
    assign inst_sram_rdata   = rdata;

`ifdef INST_BRIDGE_RERR_EN
    assign inst_sram_rerr = !reset && beat_done && rresp[1];
    logic unused_ok;
    assign unused_ok = ^{rlast, rresp[0]};
`else
    logic unused_ok;
    assign unused_ok = ^{rlast, rresp};
`endif

    inst_req_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .push      (slot_push),
        .pop       (slot_pop),
        .push_addr (inst_sram_addr),
        .valid     (pend_valid),
        .addr      (pend_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_AR;
            ST_AR:   if (arready) state_nxt = ST_R;
            ST_R:    if (beat_done) state_nxt = (pend_valid || accept) ? ST_AR : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pending address takes priority so requests issue in acceptance order.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr <= 32'd0;
        end else if ((state == ST_IDLE) && accept) begin
            araddr <= inst_sram_addr;
        end else if (beat_done) begin
            if (pend_valid) begin
                araddr <= pend_addr;
            end else if (accept) begin
                araddr <= inst_sram_addr;
            end
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// tb/tb_inst_axi_rd_bridge.sv - table-driven cycle vectors plus reset and handshake-count sequences
module tb_inst_axi_rd_bridge;

    logic        clk;
    logic        reset;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        inst_sram_rerr;

    inst_axi_rd_bridge u_dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arvalid           (arvalid),
        .arready           (arready),
        .rdata             (rdata),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
`ifdef INST_BRIDGE_RERR_EN
        ,
        .inst_sram_rerr    (inst_sram_rerr)
`endif
    );

`ifndef INST_BRIDGE_RERR_EN
    assign inst_sram_rerr = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        ar_rdy;
        logic        r_vld;
        logic [31:0] r_data;
        logic [1:0]  r_resp;
        logic        e_aok;
        logic        e_dok;
        logic        e_arv;
        logic        e_rr;
        logic [31:0] e_araddr;
        logic        e_rerr;
    } vec_t;

    vec_t vecs[38];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   hs_cnt = 0;
    int   dok_cnt = 0;

    function automatic vec_t v(input logic req, input logic [31:0] addr, input logic ar_rdy,
                               input logic r_vld, input logic [31:0] r_data, input logic [1:0] r_resp,
                               input logic e_aok, input logic e_dok, input logic e_arv,
                               input logic e_rr, input logic [31:0] e_araddr, input logic e_rerr);
        vec_t x;
        x.req = req; x.addr = addr; x.ar_rdy = ar_rdy; x.r_vld = r_vld;
        x.r_data = r_data; x.r_resp = r_resp; x.e_aok = e_aok; x.e_dok = e_dok;
        x.e_arv = e_arv; x.e_rr = e_rr; x.e_araddr = e_araddr; x.e_rerr = e_rerr;
        return x;
    endfunction

    task automatic check(input string nm, input logic ok, input string got, input string want);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %s required %s", nm, got, want);
    endtask

    // Called at a negedge: drive, settle, compare, advance one clock.
    task automatic step(input vec_t x, input string nm);
        logic ok;
        inst_sram_req  = x.req;
        inst_sram_addr = x.addr;
        arready        = x.ar_rdy;
        rvalid         = x.r_vld;
        rdata          = x.r_data;
        rresp          = x.r_resp;
        #1;
        ok = (inst_sram_addr_ok === x.e_aok) && (inst_sram_data_ok === x.e_dok) &&
             (arvalid === x.e_arv) && (rready === x.e_rr) && (araddr === x.e_araddr);
        if (x.e_dok) ok = ok && (inst_sram_rdata === x.r_data);
`ifdef INST_BRIDGE_RERR_EN
        ok = ok && (inst_sram_rerr === x.e_rerr);
`endif
        check(nm, ok,
              $sformatf("aok=%b dok=%b arv=%b rr=%b araddr=%h rdata=%h rerr=%b",
                        inst_sram_addr_ok, inst_sram_data_ok, arvalid, rready, araddr,
                        inst_sram_rdata, inst_sram_rerr),
              $sformatf("aok=%b dok=%b arv=%b rr=%b araddr=%h rdata=%h rerr=%b",
                        x.e_aok, x.e_dok, x.e_arv, x.e_rr, x.e_araddr, x.r_data, x.e_rerr));
        if (arvalid && arready) hs_cnt++;
        if (inst_sram_data_ok) dok_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'hdeadbeef;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0; rresp = 2'b10; rlast = 1'b1;

        // single fetch
        vecs[0]  = v(1, 32'hbfc00000, 1, 0, 32'h0,        2'b00, 1, 0, 0, 0, 32'h00000000, 0);
        vecs[1]  = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'hbfc00000, 0);
        vecs[2]  = v(0, 32'h0,        1, 1, 32'h3c1d0000, 2'b00, 0, 1, 0, 1, 32'hbfc00000, 0);
        vecs[3]  = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 0, 0, 32'hbfc00000, 0);
        // AR backpressure, 5 stalled cycles
        vecs[4]  = v(1, 32'hbfc00010, 0, 0, 32'h0,        2'b00, 1, 0, 0, 0, 32'hbfc00000, 0);
        for (int i = 5; i < 10; i++)
            vecs[i] = v(0, 32'h0,     0, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'hbfc00010, 0);
        vecs[10] = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'hbfc00010, 0);
        vecs[11] = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 0, 1, 32'hbfc00010, 0);
        vecs[12] = v(0, 32'h0,        0, 1, 32'h11111111, 2'b01, 0, 1, 0, 1, 32'hbfc00010, 0);
        // flush overlap
        vecs[13] = v(1, 32'hbfc00004, 1, 0, 32'h0,        2'b00, 1, 0, 0, 0, 32'hbfc00010, 0);
        vecs[14] = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'hbfc00004, 0);
        vecs[15] = v(1, 32'hbfc00380, 0, 0, 32'h0,        2'b00, 1, 0, 0, 1, 32'hbfc00004, 0);
        vecs[16] = v(0, 32'h0,        0, 1, 32'h22222222, 2'b00, 0, 1, 0, 1, 32'hbfc00004, 0);
        vecs[17] = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'hbfc00380, 0);
        vecs[18] = v(0, 32'h0,        0, 1, 32'h33333333, 2'b10, 0, 1, 0, 1, 32'hbfc00380, 1);
        // slot full: third request held until beat_done
        vecs[19] = v(1, 32'h00001000, 0, 0, 32'h0,        2'b00, 1, 0, 0, 0, 32'hbfc00380, 0);
        vecs[20] = v(1, 32'h00002000, 0, 0, 32'h0,        2'b00, 1, 0, 1, 0, 32'h00001000, 0);
        vecs[21] = v(1, 32'h00003000, 1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'h00001000, 0);
        vecs[22] = v(1, 32'h00003000, 0, 0, 32'h0,        2'b00, 0, 0, 0, 1, 32'h00001000, 0);
        vecs[23] = v(1, 32'h00003000, 0, 1, 32'h44444444, 2'b00, 1, 1, 0, 1, 32'h00001000, 0);
        vecs[24] = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'h00002000, 0);
        vecs[25] = v(0, 32'h0,        0, 1, 32'h55555555, 2'b11, 0, 1, 0, 1, 32'h00002000, 1);
        vecs[26] = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'h00003000, 0);
        vecs[27] = v(0, 32'h0,        0, 1, 32'h66666666, 2'b00, 0, 1, 0, 1, 32'h00003000, 0);
        // back-to-back with zero-wait slave
        vecs[28] = v(1, 32'h00000000, 1, 1, 32'h0,        2'b00, 1, 0, 0, 0, 32'h00003000, 0);
        vecs[29] = v(1, 32'h00000004, 1, 1, 32'h0,        2'b00, 1, 0, 1, 0, 32'h00000000, 0);
        vecs[30] = v(1, 32'h00000008, 1, 1, 32'h000000d0, 2'b00, 1, 1, 0, 1, 32'h00000000, 0);
        vecs[31] = v(0, 32'h0,        1, 1, 32'h0,        2'b00, 0, 0, 1, 0, 32'h00000004, 0);
        vecs[32] = v(0, 32'h0,        1, 1, 32'h000000d4, 2'b00, 0, 1, 0, 1, 32'h00000004, 0);
        vecs[33] = v(0, 32'h0,        1, 1, 32'h0,        2'b00, 0, 0, 1, 0, 32'h00000008, 0);
        // request arriving with beat_done and empty slot goes straight to AR
        vecs[34] = v(1, 32'h0000000c, 1, 1, 32'h000000d8, 2'b00, 1, 1, 0, 1, 32'h00000008, 0);
        vecs[35] = v(0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 1, 0, 32'h0000000c, 0);
        vecs[36] = v(0, 32'h0,        0, 1, 32'h000000dc, 2'b00, 0, 1, 0, 1, 32'h0000000c, 0);
        vecs[37] = v(0, 32'h0,        0, 0, 32'h0,        2'b00, 0, 0, 0, 0, 32'h0000000c, 0);

        @(posedge clk);
        @(negedge clk);
        step(v(1, 32'hdeadbeef, 1, 1, 32'h0, 2'b10, 0, 0, 0, 0, 32'h0, 0), "reset_state");
        check("ar_constants", (arid === 4'h0) && (arlen === 8'd0) && (arsize === 3'd2) && (arburst === 2'b01),
              $sformatf("%h/%h/%h/%h", arid, arlen, arsize, arburst), "0/00/2/1");
        reset = 1'b0;

        for (int i = 0; i < 38; i++) step(vecs[i], $sformatf("vec%0d", i));

        // reset while in R with a pending request and a beat on the bus
        step(v(1, 32'h000000a0, 1, 0, 32'h0, 2'b00, 1, 0, 0, 0, 32'h0000000c, 0), "rst_seq_req");
        step(v(0, 32'h0,        1, 0, 32'h0, 2'b00, 0, 0, 1, 0, 32'h000000a0, 0), "rst_seq_ar");
        step(v(1, 32'h000000b0, 0, 0, 32'h0, 2'b00, 1, 0, 0, 1, 32'h000000a0, 0), "rst_seq_pend");
        reset = 1'b1;
        step(v(1, 32'h000000b0, 0, 1, 32'h77777777, 2'b10, 0, 0, 0, 1, 32'h000000a0, 0), "rst_during_r");
        reset = 1'b0;
        step(v(0, 32'h0, 0, 1, 32'h88888888, 2'b10, 0, 0, 0, 0, 32'h0, 0), "rst_after_r");
        check("rst_pend_cleared", u_dut.pend_valid === 1'b0,
              $sformatf("%b", u_dut.pend_valid), "0");

        check("ar_handshakes", hs_cnt == 12, $sformatf("%0d", hs_cnt), "12");
        check("data_ok_pulses", dok_cnt == 11, $sformatf("%0d", dok_cnt), "11");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
